// File: rtl/bnorm_pkg.sv
// Shared fixed-point constants, reset values and the saturating ReLU used by
// the batch-norm channel block.
package bnorm_pkg;

    localparam int FRAC        = 8;
    localparam int DATA_W_DEF  = 16;
    localparam int PARAM_W_DEF = 12;
    localparam int OUT_W_DEF   = 12;

    localparam logic [11:0] THETA_ONE = 12'h100;
    localparam logic [11:0] PHI_ZERO  = 12'h000;

    // Clamp a signed value into the unsigned range [0, 2^out_w - 1].
    function automatic logic [31:0] sat_relu(input logic signed [31:0] x, input int out_w);
        logic signed [31:0] max_v;
        max_v = $signed((32'd1 << out_w) - 32'd1);
        if (x < 0) begin
            return '0;
        end
        if (x > max_v) begin
            return $unsigned(max_v);
        end
        return $unsigned(x);
    endfunction

endpackage

// File: rtl/bnorm_param_rf.sv
// Per-channel theta/phi storage: one write port, one combinational read port,
// asynchronously reset to identity scaling.
module bnorm_param_rf
    import bnorm_pkg::*;
#(
    parameter int NUM_CH  = 16,
    parameter int PARAM_W = PARAM_W_DEF
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      we,
    input  logic [$clog2(NUM_CH)-1:0] wr_addr,
    input  logic [PARAM_W-1:0]        wr_theta,
    input  logic [PARAM_W-1:0]        wr_phi,
    input  logic [$clog2(NUM_CH)-1:0] rd_addr,
    output logic [PARAM_W-1:0]        rd_theta,
    output logic [PARAM_W-1:0]        rd_phi
);

    logic [PARAM_W-1:0] theta_q [NUM_CH];
    logic [PARAM_W-1:0] phi_q   [NUM_CH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                theta_q[i] <= PARAM_W'(THETA_ONE);
                phi_q[i]   <= PARAM_W'(PHI_ZERO);
            end
        end else if (we && (int'(wr_addr) < NUM_CH)) begin
            theta_q[wr_addr] <= wr_theta;
            phi_q[wr_addr]   <= wr_phi;
        end
    end

    // Read returns the pre-write value during a write cycle.
    assign rd_theta = theta_q[rd_addr];
    assign rd_phi   = phi_q[rd_addr];

endmodule

// File: rtl/bnorm_ch.sv
// Two-stage per-channel batch-norm (scale, shift) with saturating ReLU.
// Optional BNORM_BIN_EN adds out_bin, the sign of the pre-activation sum.
module bnorm_ch
    import bnorm_pkg::*;
#(
    parameter int NUM_CH  = 16,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int PARAM_W = PARAM_W_DEF,
    parameter int OUT_W   = OUT_W_DEF,
    parameter int FRAC    = bnorm_pkg::FRAC
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      cfg_we,
    input  logic [$clog2(NUM_CH)-1:0] cfg_addr,
    input  logic [PARAM_W-1:0]        cfg_theta,
    input  logic [PARAM_W-1:0]        cfg_phi,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic                      in_first,
    input  logic [DATA_W-1:0]         data_in,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [OUT_W-1:0]          out,
    output logic [$clog2(NUM_CH)-1:0] out_ch
`ifdef BNORM_BIN_EN
    ,
    output logic                      out_bin
`endif
);

    localparam int CH_W   = $clog2(NUM_CH);
    localparam int PROD_W = DATA_W + PARAM_W;
    localparam int SUM_W  = PROD_W + 1;

    logic                      stall;
    logic                      accept;
    logic                      s1_en;
    logic [CH_W-1:0]           ch_cnt;
    logic [CH_W-1:0]           ch_sel;
    logic [PARAM_W-1:0]        rd_theta;
    logic [PARAM_W-1:0]        rd_phi;
    logic signed [PROD_W-1:0]  prod_c;

    logic                      s1_valid;
    logic signed [PROD_W-1:0]  s1_prod;
    logic [PARAM_W-1:0]        s1_phi;
    logic [CH_W-1:0]           s1_ch;

    logic signed [PROD_W-1:0]  shifted_c;
    logic signed [SUM_W-1:0]   sum_c;
    logic [OUT_W-1:0]          act_c;

    assign stall    = out_valid && !out_ready;
    assign in_ready = !(s1_valid && stall);
    assign accept   = in_valid && in_ready;
    assign s1_en    = !stall || !s1_valid;
    assign ch_sel   = in_first ? '0 : ch_cnt;

    bnorm_param_rf #(
        .NUM_CH  (NUM_CH),
        .PARAM_W (PARAM_W)
    ) u_param_rf (
        .clk      (clk),
        .rst_n    (rst_n),
        .we       (cfg_we),
        .wr_addr  (cfg_addr),
        .wr_theta (cfg_theta),
        .wr_phi   (cfg_phi),
        .rd_addr  (ch_sel),
        .rd_theta (rd_theta),
        .rd_phi   (rd_phi)
    );

    // Both operands sign-extended to the full product width first.
    always_comb begin
        prod_c = PROD_W'($signed(data_in)) * PROD_W'($signed(rd_theta));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ch_cnt   <= '0;
            s1_valid <= 1'b0;
            s1_prod  <= '0;
            s1_phi   <= '0;
            s1_ch    <= '0;
        end else begin
            if (s1_en) begin
                s1_valid <= accept;
            end
            if (accept) begin
                ch_cnt  <= (ch_sel == CH_W'(NUM_CH - 1)) ? '0 : ch_sel + CH_W'(1);
                s1_prod <= prod_c;
                s1_phi  <= rd_phi;
                s1_ch   <= ch_sel;
            end
        end
    end

    // Arithmetic shift floors toward minus infinity.
    always_comb begin
        shifted_c = s1_prod >>> FRAC;
        sum_c     = SUM_W'(shifted_c) + SUM_W'($signed(s1_phi));
        act_c     = OUT_W'(sat_relu(32'(sum_c), OUT_W));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out       <= '0;
            out_ch    <= '0;
        end else if (!stall) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out    <= act_c;
                out_ch <= s1_ch;
            end
        end
    end

`ifdef BNORM_BIN_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_bin <= 1'b0;
        end else if (!stall && s1_valid) begin
            out_bin <= !sum_c[SUM_W-1];
        end
    end
`endif

endmodule

// File: doc/bnorm_ch.md
BNORM_CH -- requirements
Module: bnorm_ch

Interface
REQ-001 Parameter NUM_CH, default 16: number of channels; per-channel theta/phi entries.
REQ-002 Parameter DATA_W, default 16: input sample width, signed Q8.8.
REQ-003 Parameter PARAM_W, default 12: theta/phi width, signed Q4.8.
REQ-004 Parameter OUT_W, default 12: output width, unsigned Q4.8.
REQ-005 Parameter FRAC, default 8: fractional bits shared by all fixed-point formats.
REQ-006 clk  in  1  single clock; all state updates on the rising edge.
REQ-007 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-008 cfg_we  in  1  parameter write strobe.
REQ-009 cfg_addr  in  $clog2(NUM_CH)  channel written.
REQ-010 cfg_theta  in  PARAM_W  scale, signed Q4.8.
REQ-011 cfg_phi  in  PARAM_W  shift, signed Q4.8.
REQ-012 in_valid  in  1  sample valid.
REQ-013 in_ready  out  1  block accepts a sample this cycle.
REQ-014 in_first  in  1  sample is channel 0 of a new frame.
REQ-015 data_in  in  DATA_W  sample, signed Q8.8.
REQ-016 out_valid  out  1  result valid.
REQ-017 out_ready  in  1  downstream accepts the result.
REQ-018 out  out  OUT_W  normalised, activated result.
REQ-019 out_ch  out  $clog2(NUM_CH)  channel index of out.

Function
REQ-020 Transfers occur on valid&&ready at each port; accepted samples are processed in order, never dropped or duplicated.
REQ-021 Channel counter: in_first=1 on an accepted sample forces channel 0; otherwise the current count is used; the counter then becomes channel+1, wrapping NUM_CH-1 -> 0.
REQ-022 Pipeline has 2 stages. S1 = signed product data_in*theta[ch], DATA_W+PARAM_W bits. S2 = arithmetic shift right by FRAC, add sign-extended phi[ch], then activate.
REQ-023 Activation clamps negative values to 0 and values above 2^OUT_W-1 to 2^OUT_W-1 (0xFFF); the shift truncates toward minus infinity.
REQ-024 Latency is 2 cycles from acceptance to out_valid when out_ready is held high; throughput is 1 sample per cycle.
REQ-025 Backpressure stalls the whole pipeline while out_valid=1 and out_ready=0; in_ready = !(S1 full && S2 stalled).
REQ-026 A cfg write is visible to samples accepted on the cycle after cfg_we. A sample accepted on the same cycle as a write to its channel uses the old value.
REQ-027 Parameters are read when the sample is accepted. Later writes do not affect in-flight samples.
REQ-028 out and out_ch hold stable while out_valid=1 and out_ready=0.

Reset
REQ-029 rst_n=0 immediately clears out_valid, both stage-valid flags, the channel counter, out and out_ch to 0; in_ready is 1 after release.
REQ-030 Reset loads every channel with theta=0x100 (1.0) and phi=0x000 (identity). In-flight samples at reset are discarded.

Configuration
REQ-031 When BNORM_BIN_EN is defined, the block adds output port out_bin (1 bit), aligned with out. out_bin=1 when the pre-activation sum is >=0, else 0, giving the sign-binarised activation for the next BCNN layer.
REQ-032 When BNORM_BIN_EN is undefined, port out_bin and its logic are absent; all other behaviour is identical.

Structure
REQ-033 Shared package bnorm_pkg holds the Q-format constants (FRAC, default widths), the reset values THETA_ONE=0x100 and PHI_ZERO=0x000, and the saturate/ReLU function.
REQ-034 Per-channel parameter storage is one sub-module, bnorm_param_rf: NUM_CH x 2 x PARAM_W, asynchronous-reset register file with one write port and one read port.

Verification
REQ-035 After reset, no cfg writes, data_in=0x0100 on ch0 -> out=0x100, out_ch=0, 2 cycles after acceptance.
REQ-036 cfg ch1 theta=0x200, phi=0x080; stream 0x0100 on ch0 then ch1 -> out 0x100 then 0x280.
REQ-037 data_in=0x7FFF, identity -> 0xFFF. data_in=0xFF00 -> 0x000, and out_bin=0 when BNORM_BIN_EN is defined.
REQ-038 NUM_CH=4, 6 back-to-back samples, in_first on samples 1 and 6 -> out_ch sequence 0,1,2,3,0,0.
REQ-039 4 samples with out_ready held low for 3 cycles -> in_ready falls, all 4 results arrive in order, out stays stable while stalled.
REQ-040 rst_n pulled low with 2 samples in flight -> out_valid=0 at once, no stale results after release, parameters reset to identity.
